// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV request: start pulse, wait for fim, one HI/LO write, done.
// Optional watchdog timeout on the WAIT state is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic req_i,
    input  logic op_i,
    output logic busy_o,
    output logic done_o,
    output logic mult_start_o,
    output logic div_start_o,
    input  logic mult_fim_i,
    input  logic div_fim_i,
    input  logic div_by_zero_i,
    output logic hi_sel_o,
    output logic lo_sel_o,
    output logic hi_write_o,
    output logic lo_write_o,
    output logic exc_div0_o,
    output logic exc_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_EXC   = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    state_t state_q, state_d;
    logic   op_q, op_d;
    logic   sel_fim;

    // Only the unit that was actually started may complete the operation.
    assign sel_fim = op_q ? div_fim_i : mult_fim_i;

`ifdef MULDIV_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       exc_to_q, exc_to_d;
    logic       to_hit;

    assign to_hit = ((cnt_q + 8'd1) == TO_LIMIT);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q    <= 8'd0;
            exc_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            exc_to_q <= exc_to_d;
        end
    end
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef MULDIV_TIMEOUT_EN
        // Counter is zero on entry to WAIT and counts completed WAIT cycles.
        cnt_d    = (state_q == S_WAIT) ? (cnt_q + 8'd1) : 8'd0;
        exc_to_d = exc_to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_d    = op_i;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // Divide-by-zero outranks fim, which outranks the watchdog.
                if (op_q && div_by_zero_i) begin
                    state_d = S_EXC;
`ifdef MULDIV_TIMEOUT_EN
                    exc_to_d = 1'b0;
`endif
                end else if (sel_fim) begin
                    state_d = S_WRITE;
`ifdef MULDIV_TIMEOUT_EN
                end else if (to_hit) begin
                    state_d  = S_EXC;
                    exc_to_d = 1'b1;
`endif
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs; op_q only changes when leaving IDLE, so the HI/LO
    // selectors naturally hold their last value while idle.
    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_o        = (state_q == S_DONE);
        mult_start_o  = (state_q == S_START) && !op_q;
        div_start_o   = (state_q == S_START) && op_q;
        hi_sel_o      = op_q;
        lo_sel_o      = op_q;
        hi_write_o    = (state_q == S_WRITE);
        lo_write_o    = (state_q == S_WRITE);
`ifdef MULDIV_TIMEOUT_EN
        exc_div0_o    = (state_q == S_EXC) && !exc_to_q;
        exc_timeout_o = (state_q == S_EXC) && exc_to_q;
`else
        exc_div0_o    = (state_q == S_EXC);
        exc_timeout_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scenario bench for muldiv_sequencer: expected HI/LO writes and exceptions
// are queued when a request is issued and matched when the DUT produces them.
module tb_muldiv_sequencer;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic req = 1'b0, op = 1'b0;
    logic mult_fim = 1'b0, div_fim = 1'b0, div_by_zero = 1'b0;
    logic busy, done, mult_start, div_start, hi_sel, lo_sel;
    logic hi_write, lo_write, exc_div0, exc_timeout;

    always #5 clock = ~clock;

    muldiv_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clock_i      (clock),
        .reset_ni     (reset_n),
        .req_i        (req),
        .op_i         (op),
        .busy_o       (busy),
        .done_o       (done),
        .mult_start_o (mult_start),
        .div_start_o  (div_start),
        .mult_fim_i   (mult_fim),
        .div_fim_i    (div_fim),
        .div_by_zero_i(div_by_zero),
        .hi_sel_o     (hi_sel),
        .lo_sel_o     (lo_sel),
        .hi_write_o   (hi_write),
        .lo_write_o   (lo_write),
        .exc_div0_o   (exc_div0),
        .exc_timeout_o(exc_timeout)
    );

`ifdef MULDIV_TIMEOUT_EN
    localparam int MULT_DLY = 5;
    localparam int DIV_DLY  = 6;
`else
    localparam int MULT_DLY = 10;
    localparam int DIV_DLY  = 33;
`endif

    typedef struct packed {
        logic       op;
        logic [1:0] kind;
    } exp_t;
    localparam logic [1:0] K_WR = 2'd0, K_DIV0 = 2'd1, K_TO = 2'd2;

    exp_t exp_q[$];
    exp_t got, want;
    int total = 0, bad = 0;
    int n_write = 0, n_done = 0, n_div0 = 0, n_to = 0, n_mst = 0, n_dst = 0;

    wire [9:0] outs = {busy, done, mult_start, div_start, hi_sel, lo_sel,
                       hi_write, lo_write, exc_div0, exc_timeout};

    always @(negedge clock) begin
        if (hi_write)    n_write++;
        if (done)        n_done++;
        if (exc_div0)    n_div0++;
        if (exc_timeout) n_to++;
        if (mult_start)  n_mst++;
        if (div_start)   n_dst++;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        total++;
        if (outs !== 10'b0) begin bad++; $display("FAIL reset_outs: got %b want %b", outs, 10'b0); end
        reset_n = 1'b1;
        step();
        step();
        total++;
        if (outs !== 10'b0) begin bad++; $display("FAIL idle_after_reset: got %b want %b", outs, 10'b0); end
    endtask

    task automatic test_mult();
        int d0 = n_dst;
        op = 1'b0; req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, K_WR});
        step(); req = 1'b0;
        total++;
        if ({mult_start, div_start, busy, hi_sel, lo_sel} !== 5'b10100) begin
            bad++; $display("FAIL mult_start_cycle: got %b want %b", {mult_start, div_start, busy, hi_sel, lo_sel}, 5'b10100);
        end
        step();
        total++;
        if (mult_start !== 1'b0) begin bad++; $display("FAIL mult_start_width: got %b want 0", mult_start); end
        for (int i = 0; i < MULT_DLY - 1; i++) step();
        mult_fim = 1'b1;
        step();
        total++;
        if ({hi_write, lo_write, done} !== 3'b110) begin
            bad++; $display("FAIL mult_write: got %b want %b", {hi_write, lo_write, done}, 3'b110);
        end
        if (hi_write === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL mult_sb: got write want nothing queued"); end
            else begin
                want = exp_q.pop_front(); got = exp_t'{hi_sel, K_WR};
                if (got !== want) begin bad++; $display("FAIL mult_sb: got %h want %h", got, want); end
            end
        end
        mult_fim = 1'b0;
        step();
        total++;
        if ({hi_write, lo_write, done, busy} !== 4'b0011) begin
            bad++; $display("FAIL mult_done: got %b want %b", {hi_write, lo_write, done, busy}, 4'b0011);
        end
        step();
        total++;
        if ({busy, done, n_dst - d0} !== {1'b0, 1'b0, 32'd0}) begin
            bad++; $display("FAIL mult_idle: got busy=%b done=%b div_starts=%0d want 0 0 0", busy, done, n_dst - d0);
        end
    endtask

    task automatic test_div();
        int k_done = -1;
        bit sel_ok = 1'b1;
        op = 1'b1; req = 1'b1;
        exp_q.push_back(exp_t'{1'b1, K_WR});
        step(); req = 1'b0;
        total++;
        if ({mult_start, div_start, hi_sel, lo_sel} !== 4'b0111) begin
            bad++; $display("FAIL div_start_cycle: got %b want %b", {mult_start, div_start, hi_sel, lo_sel}, 4'b0111);
        end
        for (int i = 0; i < DIV_DLY - 1; i++) begin
            step();
            if (hi_sel !== 1'b1 || lo_sel !== 1'b1 || div_start !== 1'b0) sel_ok = 1'b0;
        end
        total++;
        if (!sel_ok) begin bad++; $display("FAIL div_wait_sel: got sel/start wrong during WAIT want sel=1 start=0"); end
        div_fim = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (hi_write === 1'b1) begin
                div_fim = 1'b0;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL div_sb: got write want nothing queued"); end
                else begin
                    want = exp_q.pop_front(); got = exp_t'{hi_sel, K_WR};
                    if (got !== want) begin bad++; $display("FAIL div_sb: got %h want %h", got, want); end
                end
            end
            if (done === 1'b1) begin k_done = k; break; end
        end
        div_fim = 1'b0;
        total++;
        if (k_done != 2) begin bad++; $display("FAIL div_done_latency: got %0d want 2", k_done); end
        step(); step(); step();
        total++;
        if ({busy, hi_sel, lo_sel} !== 3'b011) begin
            bad++; $display("FAIL div_sel_hold: got %b want %b", {busy, hi_sel, lo_sel}, 3'b011);
        end
    endtask

    task automatic test_div0();
        int w0 = n_write, dn0 = n_done, v0 = n_div0;
        op = 1'b1; req = 1'b1;
        exp_q.push_back(exp_t'{1'b1, K_DIV0});
        step(); req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        div_by_zero = 1'b1; div_fim = 1'b1;
        step();
        total++;
        if ({exc_div0, hi_write, exc_timeout, done} !== 4'b1000) begin
            bad++; $display("FAIL div0_exc: got %b want %b", {exc_div0, hi_write, exc_timeout, done}, 4'b1000);
        end
        if (exc_div0 === 1'b1 || hi_write === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL div0_sb: got event want nothing queued"); end
            else begin
                want = exp_q.pop_front(); got = exp_t'{hi_sel, exc_div0 ? K_DIV0 : K_WR};
                if (got !== want) begin bad++; $display("FAIL div0_sb: got %h want %h", got, want); end
            end
        end
        div_by_zero = 1'b0; div_fim = 1'b0;
        step();
        total++;
        if ({busy, exc_div0} !== 2'b00) begin bad++; $display("FAIL div0_idle: got %b want 00", {busy, exc_div0}); end
        step(); step();
        total++;
        if (n_write != w0 || n_done != dn0 || n_div0 != v0 + 1) begin
            bad++; $display("FAIL div0_counts: got w=%0d d=%0d e=%0d want w=0 d=0 e=1", n_write - w0, n_done - dn0, n_div0 - v0);
        end
    endtask

    task automatic test_spurious();
        int m0 = n_mst, d0 = n_dst;
        bit quiet = 1'b1;
        op = 1'b0; req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, K_WR});
        step(); req = 1'b0;
        step();
        req = 1'b1; div_fim = 1'b1; div_by_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (hi_write !== 1'b0 || exc_div0 !== 1'b0 || busy !== 1'b1 || mult_start !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL spurious_ignored: got activity in WAIT want none"); end
        req = 1'b0; div_fim = 1'b0; div_by_zero = 1'b0; mult_fim = 1'b1;
        step();
        total++;
        if (hi_write !== 1'b1) begin bad++; $display("FAIL spurious_write: got %b want 1", hi_write); end
        else begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL spurious_sb: got write want nothing queued"); end
            else begin
                want = exp_q.pop_front(); got = exp_t'{hi_sel, K_WR};
                if (got !== want) begin bad++; $display("FAIL spurious_sb: got %h want %h", got, want); end
            end
        end
        mult_fim = 1'b0;
        step(); step(); step();
        total++;
        if (n_mst - m0 != 1 || n_dst != d0 || busy !== 1'b0) begin
            bad++; $display("FAIL spurious_starts: got mst=%0d dst=%0d busy=%b want 1 0 0", n_mst - m0, n_dst - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int m0 = n_mst;
        int d_first = -1, d_second = -1, idle5 = -1;
        mult_fim = 1'b1;
        op = 1'b0; req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, K_WR});
        exp_q.push_back(exp_t'{1'b0, K_WR});
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 5) idle5 = int'(busy);
            if (k == 6) req = 1'b0;
            if (hi_write === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb: got write want nothing queued"); end
                else begin
                    want = exp_q.pop_front(); got = exp_t'{hi_sel, K_WR};
                    if (got !== want) begin bad++; $display("FAIL b2b_sb: got %h want %h", got, want); end
                end
            end
            if (done === 1'b1) begin
                if (d_first < 0) d_first = k; else if (d_second < 0) d_second = k;
            end
        end
        mult_fim = 1'b0; req = 1'b0;
        total++;
        if (d_first != 4 || d_second != 9 || idle5 != 0) begin
            bad++; $display("FAIL b2b_timing: got done@%0d,%0d busy5=%0d want 4,9,0", d_first, d_second, idle5);
        end
        total++;
        if (n_mst - m0 != 2) begin bad++; $display("FAIL b2b_starts: got %0d want 2", n_mst - m0); end
    endtask

    task automatic test_async_reset();
        int w0, dn0;
        op = 1'b0; req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, K_WR});
        step(); req = 1'b0;
        step(); step(); step();
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (outs !== 10'b0) begin bad++; $display("FAIL async_reset_outs: got %b want %b", outs, 10'b0); end
        exp_q.delete();
        w0 = n_write; dn0 = n_done;
        step();
        reset_n = 1'b1;
        step();
        mult_fim = 1'b1;
        for (int i = 0; i < 4; i++) step();
        mult_fim = 1'b0;
        total++;
        if (n_write != w0 || n_done != dn0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset_after: got w=%0d d=%0d busy=%b want 0 0 0", n_write - w0, n_done - dn0, busy);
        end
    endtask

    task automatic test_timeout();
        int w0 = n_write;
`ifdef MULDIV_TIMEOUT_EN
        int k_exc = -1;
        op = 1'b0; req = 1'b1;
        exp_q.push_back(exp_t'{1'b0, K_TO});
        step(); req = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            step();
            if (exc_timeout === 1'b1 || exc_div0 === 1'b1) begin
                k_exc = k;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL timeout_sb: got exception want nothing queued"); end
                else begin
                    want = exp_q.pop_front(); got = exp_t'{hi_sel, exc_timeout ? K_TO : K_DIV0};
                    if (got !== want) begin bad++; $display("FAIL timeout_sb: got %h want %h", got, want); end
                end
                break;
            end
        end
        total++;
        if (k_exc != 10) begin bad++; $display("FAIL timeout_latency: got %0d want 10", k_exc); end
        step();
        total++;
        if (busy !== 1'b0 || n_write != w0) begin
            bad++; $display("FAIL timeout_idle: got busy=%b writes=%0d want 0 0", busy, n_write - w0);
        end
`else
        bit held = 1'b1;
        op = 1'b0; req = 1'b1;
        step(); req = 1'b0;
        for (int i = 0; i < 110; i++) begin
            step();
            if (busy !== 1'b1 || exc_timeout !== 1'b0 || hi_write !== 1'b0) held = 1'b0;
        end
        total++;
        if (!held || n_write != w0) begin
            bad++; $display("FAIL no_timeout_wait: got held=%b writes=%0d want 1 0", held, n_write - w0);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        total++;
        if (outs !== 10'b0) begin bad++; $display("FAIL no_timeout_recover: got %b want %b", outs, 10'b0); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_spurious();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
